// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared constants and types for the instruction fetch stage:
//               datapath widths, the NOP encoding presented when no
//               instruction is available, the fetch FSM state encoding and
//               the instruction buffer entry layout.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int XLEN     = 32;
    localparam int OPCODE_W = 7;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Fetch FSM: REQ may issue a request, WAIT holds the single outstanding one
    typedef enum logic [0:0] {
        REQ  = 1'b0,
        WAIT = 1'b1
    } fetch_state_t;

    // One buffered instruction together with the address it was fetched from
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Synchronous instruction buffer holding {pc, instr} entries.
//               Simultaneous push and pop are allowed; flush empties the
//               buffer and takes priority over push and pop.
// Ports       : i_clk, i_rst_n      - clock, asynchronous active-low reset
//               i_push, i_push_data - write one entry at the tail
//               i_pop               - retire the head entry
//               i_flush             - discard all entries
//               o_head              - head entry (undefined when empty)
//               o_count             - number of valid entries
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  fetch_entry_t     i_push_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output fetch_entry_t     o_head,
    output logic [CNT_W-1:0] o_count
);

    localparam logic [CNT_W-1:0] c_FULL = CNT_W'(DEPTH);

    fetch_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_pop;
    logic w_push;

    // Guard against popping an empty buffer or pushing into a full one that
    // is not draining in the same cycle; the fetch FSM never does either.
    assign w_pop  = i_pop && (r_count != '0);
    assign w_push = i_push && ((r_count != c_FULL) || w_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only observed once counted valid.
    always_ff @(posedge i_clk) begin
        if (w_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : RV32I instruction fetch stage. Owns the PC, issues at most
//               one outstanding request on an in-order req/gnt/rvalid memory
//               port and buffers returned words for decode. A redirect from
//               execute flushes the buffer, restarts fetch at the target and
//               discards any response still in flight.
// Ports       : i_clk, i_rst_n                - clock, async active-low reset
//               i_redirect, i_redirect_pc     - flush and restart fetch
//               o_imem_req, o_imem_addr       - fetch request / word address
//               i_imem_gnt                    - request accepted
//               i_imem_rvalid, i_imem_rdata   - in-order response
//               o_valid, o_instr, o_opcode,
//               o_pc, i_ready                 - buffer head towards decode
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_redirect,
    input  logic [XLEN-1:0]     i_redirect_pc,
    output logic                o_imem_req,
    output logic [XLEN-1:0]     o_imem_addr,
    input  logic                i_imem_gnt,
    input  logic                i_imem_rvalid,
    input  logic [XLEN-1:0]     i_imem_rdata,
    output logic                o_valid,
    output logic [XLEN-1:0]     o_instr,
    output logic [OPCODE_W-1:0] o_opcode,
    output logic [XLEN-1:0]     o_pc,
    input  logic                i_ready
);

    localparam int               CNT_W       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] c_FIFO_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [XLEN-1:0]  c_WORD_MASK = 32'hFFFF_FFFC;

    fetch_state_t    r_state;
    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_inflight_pc;
    logic            r_drop;

    logic             w_fire;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic [CNT_W-1:0] w_count;
    fetch_entry_t     w_head;
    fetch_entry_t     w_push_data;

    // A request is only raised while a buffer slot is free, which reserves
    // room for its response. Gating with the reset keeps the request low
    // for the whole reset interval, not just after the next edge.
    assign w_full      = (w_count == c_FIFO_FULL);
    assign o_imem_req  = i_rst_n && (r_state == REQ) && !w_full;
    assign o_imem_addr = r_fetch_pc;
    assign w_fire      = o_imem_req && i_imem_gnt;

    // A response is buffered only if no redirect has made it stale; rvalid
    // seen outside WAIT is a protocol violation and is ignored.
    assign w_push      = (r_state == WAIT) && i_imem_rvalid && !r_drop && !i_redirect;
    assign w_pop       = o_valid && i_ready && !i_redirect;
    assign w_push_data = '{pc: r_inflight_pc, instr: i_imem_rdata};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= REQ;
            r_fetch_pc    <= RESET_PC;
            r_inflight_pc <= '0;
            r_drop        <= 1'b0;
        end else if (i_redirect) begin
            r_fetch_pc <= i_redirect_pc & c_WORD_MASK;
            // A request that is (or is just becoming) outstanding will still
            // return a word; wait for it and throw it away.
            if (((r_state == WAIT) && !i_imem_rvalid) ||
                ((r_state == REQ) && w_fire)) begin
                r_drop  <= 1'b1;
                r_state <= WAIT;
            end else begin
                r_drop  <= 1'b0;
                r_state <= REQ;
            end
        end else begin
            case (r_state)
                REQ: begin
                    if (w_fire) begin
                        r_inflight_pc <= r_fetch_pc;
                        r_fetch_pc    <= r_fetch_pc + 32'd4;
                        r_state       <= WAIT;
                    end
                end
                WAIT: begin
                    if (i_imem_rvalid) begin
                        r_drop  <= 1'b0;
                        r_state <= REQ;
                    end
                end
                default: begin
                    r_state <= REQ;
                end
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .i_flush     (i_redirect),
        .o_head      (w_head),
        .o_count     (w_count)
    );

    // Outputs come only from buffer state, so decode never sees a
    // combinational path from the memory read data.
    assign o_valid  = (w_count != '0);
    assign o_instr  = o_valid ? w_head.instr : NOP_INSTR;
    assign o_opcode = o_instr[OPCODE_W-1:0];
    assign o_pc     = o_valid ? w_head.pc : '0;

endmodule : fetch_stage
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Self-checking bench for fetch_stage. A memory responder
//               returns a deterministic word per address after a chosen
//               latency; every granted, non-stale request pushes its expected
//               {pc, instr} into a scoreboard that is popped whenever decode
//               accepts the buffer head. Directed scenarios cover streaming,
//               backpressure, redirects, PC wrap and asynchronous reset,
//               followed by a randomised run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] c_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] c_NOP      = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } sb_t;

    logic        clk;
    logic        rst_n;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        valid;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [31:0] pc;
    logic        ready;

    fetch_stage #(
        .RESET_PC   (c_RESET_PC),
        .FIFO_DEPTH (2)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .o_imem_req    (imem_req),
        .o_imem_addr   (imem_addr),
        .i_imem_gnt    (imem_gnt),
        .i_imem_rvalid (imem_rvalid),
        .i_imem_rdata  (imem_rdata),
        .o_valid       (valid),
        .o_instr       (instr),
        .o_opcode      (opcode),
        .o_pc          (pc),
        .i_ready       (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    sb_t         sb [$];
    logic [31:0] exp_addr;
    bit          pend;
    logic [31:0] pend_addr;
    int          pend_due;
    int          lat;
    int          gcyc;
    int          ph;
    int          grants;
    bit          prev_rdr;
    bit          last_fire;
    logic [31:0] last_addr;
    logic [31:0] last_valid;
    logic [31:0] last_req;
    logic [31:0] last_pc;
    logic [31:0] obs_req   [256];
    logic [31:0] obs_fire  [256];
    logic [31:0] obs_addr  [256];
    logic [31:0] obs_valid [256];
    logic [31:0] obs_pc    [256];
    logic [31:0] obs_instr [256];
    logic [31:0] obs_opc   [256];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, expv, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return (a * 32'd2654435761) ^ 32'h0000_0013;
    endfunction

    // One clock cycle: drive inputs at the falling edge, sample 1 time unit
    // later, update the scoreboard for what the next rising edge will do.
    task automatic cycle(input bit rdr, input logic [31:0] rpc, input bit rdy, input bit g);
        bit  fire;
        sb_t e;
        @(negedge clk);
        gcyc++;
        ph++;
        redirect    = rdr;
        redirect_pc = rpc;
        ready       = rdy;
        imem_gnt    = g;
        if (pend && (gcyc == pend_due)) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend_addr);
            pend        = 1'b0;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'hDEAD_BEEF;
        end
        #1;
        fire = imem_req && imem_gnt;
        if (ph < 256) begin
            obs_req[ph]   = {31'b0, imem_req};
            obs_fire[ph]  = {31'b0, fire};
            obs_addr[ph]  = imem_addr;
            obs_valid[ph] = {31'b0, valid};
            obs_pc[ph]    = pc;
            obs_instr[ph] = instr;
            obs_opc[ph]   = {25'b0, opcode};
        end
        last_fire  = fire;
        last_addr  = imem_addr;
        last_valid = {31'b0, valid};
        last_req   = {31'b0, imem_req};
        last_pc    = pc;
        if (prev_rdr) check("valid_after_redirect", {31'b0, valid}, 32'd0);
        if (!valid) begin
            check("idle_instr", instr, c_NOP);
            check("idle_pc", pc, 32'd0);
        end
        if (valid && ready && !rdr) begin
            if (sb.size() == 0) begin
                check("unexpected_pop", {31'b0, valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("pop_pc", pc, e.pc);
                check("pop_instr", instr, e.instr);
                check("pop_opcode", {25'b0, opcode}, {25'b0, e.instr[6:0]});
            end
        end
        if (fire) begin
            check("req_addr", imem_addr, exp_addr);
            grants++;
            pend      = 1'b1;
            pend_addr = imem_addr;
            pend_due  = gcyc + lat;
            if (!rdr) sb.push_back('{pc: exp_addr, instr: mem_word(exp_addr)});
        end
        if (rdr) begin
            sb.delete();
            exp_addr = rpc & 32'hFFFF_FFFC;
        end else if (fire) begin
            exp_addr = exp_addr + 32'd4;
        end
        prev_rdr = rdr;
    endtask

    task automatic clear_model();
        pend        = 1'b0;
        imem_rvalid = 1'b0;
        redirect    = 1'b0;
        prev_rdr    = 1'b0;
        sb.delete();
        exp_addr    = c_RESET_PC;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        ph = 0;
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          found;
        logic [31:0] fa0;
        logic [31:0] fa1;
        logic [31:0] fpc;
        int          nf;

        rst_n       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_gnt    = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        ready       = 1'b1;
        lat         = 1;
        gcyc        = 0;
        ph          = 0;
        grants      = 0;
        pend_due    = 0;
        pend_addr   = 32'h0;
        clear_model();

        // Reset state
        #12;
        check("rst_valid", {31'b0, valid}, 32'd0);
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, c_RESET_PC);
        check("rst_instr", instr, c_NOP);
        check("rst_opcode", {25'b0, opcode}, 32'h13);
        check("rst_pc", pc, 32'd0);

        // Streaming at one-cycle memory latency
        do_reset();
        lat = 1;
        repeat (6) cycle(1'b0, 32'h0, 1'b1, 1'b1);
        check("strm_fire_c1", obs_fire[1], 32'd1);
        check("strm_addr_c1", obs_addr[1], 32'h0);
        check("strm_fire_c2", obs_fire[2], 32'd0);
        check("strm_fire_c3", obs_fire[3], 32'd1);
        check("strm_addr_c3", obs_addr[3], 32'h4);
        check("strm_fire_c4", obs_fire[4], 32'd0);
        check("strm_addr_c5", obs_addr[5], 32'h8);
        check("strm_valid_c2", obs_valid[2], 32'd0);
        check("strm_valid_c3", obs_valid[3], 32'd1);
        check("strm_pc_c3", obs_pc[3], 32'h0);
        check("strm_instr_c3", obs_instr[3], 32'h0050_0093);
        check("strm_opcode_c3", obs_opc[3], 32'h13);

        // Backpressure: buffer fills after two grants, then the port idles
        do_reset();
        grants = 0;
        repeat (8) cycle(1'b0, 32'h0, 1'b0, 1'b1);
        check("bp_grants", grants, 32'd2);
        check("bp_req_idle", obs_req[8], 32'd0);
        check("bp_valid", obs_valid[8], 32'd1);
        repeat (2) cycle(1'b0, 32'h0, 1'b1, 1'b1);
        check("bp_pop0_pc", obs_pc[9], 32'h0);
        check("bp_pop1_pc", obs_pc[10], 32'h4);
        check("bp_next_fire", obs_fire[10], 32'd1);
        check("bp_next_addr", obs_addr[10], 32'h8);

        // Redirect while the addr-8 request is outstanding
        do_reset();
        lat   = 3;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            cycle(1'b0, 32'h0, 1'b1, 1'b1);
            if (last_fire && last_addr == 32'h8) found = 1'b1;
        end
        check("rdw_found_fire8", {31'b0, found}, 32'd1);
        cycle(1'b1, 32'h100, 1'b1, 1'b1);
        lat = 1;
        fa0 = 32'hFFFF_FFFF;
        fpc = 32'hFFFF_FFFF;
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, 32'h0, 1'b1, 1'b1);
            if (last_fire && fa0 == 32'hFFFF_FFFF) fa0 = last_addr;
            if (last_valid[0] && fpc == 32'hFFFF_FFFF) fpc = last_pc;
        end
        check("rdw_first_addr", fa0, 32'h100);
        check("rdw_first_pc", fpc, 32'h100);

        // Redirect with a full buffer and decode ready in the same cycle
        repeat (8) cycle(1'b0, 32'h0, 1'b0, 1'b1);
        check("rdf_full_valid", last_valid, 32'd1);
        check("rdf_full_req", last_req, 32'd0);
        cycle(1'b1, 32'h203, 1'b1, 1'b1);
        cycle(1'b0, 32'h0, 1'b1, 1'b1);
        check("rdf_valid_after", last_valid, 32'd0);
        check("rdf_fire", {31'b0, last_fire}, 32'd1);
        check("rdf_addr", last_addr, 32'h200);
        repeat (4) cycle(1'b0, 32'h0, 1'b1, 1'b1);

        // Address wrap
        cycle(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
        fa0 = 32'h1234_5678;
        fa1 = 32'h1234_5678;
        nf  = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, 32'h0, 1'b1, 1'b1);
            if (last_fire) begin
                if (nf == 0) fa0 = last_addr;
                if (nf == 1) fa1 = last_addr;
                nf++;
            end
        end
        check("wrap_addr0", fa0, 32'hFFFF_FFFC);
        check("wrap_addr1", fa1, 32'h0000_0000);

        // Asynchronous reset in WAIT with a non-empty buffer
        lat   = 3;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle(1'b0, 32'h0, 1'b0, 1'b1);
            if (last_fire && last_valid[0]) found = 1'b1;
        end
        check("ar_found_wait", {31'b0, found}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_valid", {31'b0, valid}, 32'd0);
        check("ar_req", {31'b0, imem_req}, 32'd0);
        check("ar_instr", instr, c_NOP);
        check("ar_opcode", {25'b0, opcode}, 32'h13);
        check("ar_pc", pc, 32'd0);
        check("ar_addr", imem_addr, c_RESET_PC);
        clear_model();
        @(posedge clk);
        #2 rst_n = 1'b1;
        ph  = 0;
        lat = 1;
        cycle(1'b0, 32'h0, 1'b1, 1'b1);
        check("ar_first_fire", obs_fire[1], 32'd1);
        check("ar_first_addr", obs_addr[1], c_RESET_PC);
        repeat (4) cycle(1'b0, 32'h0, 1'b1, 1'b1);

        // Randomised traffic: grant stalls, backpressure, latencies, redirects
        for (int i = 0; i < 400; i++) begin
            bit          r;
            logic [31:0] t;
            lat = $urandom_range(1, 3);
            r   = ($urandom_range(0, 19) == 0);
            t   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : $urandom;
            cycle(r, t, ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_fetch_stage
`default_nettype wire
